// File: rtl/evg_dbus_generator.sv
// Distributed-bus source for the event generator TX path: heartbeat, round-trip ping
// and PULSE_CHANNELS programmable pulse trains, all registered in the evgTxClk domain.
module evg_dbus_generator #(
    parameter int DISTRIBUTED_BUS_WIDTH = 8,
    parameter int PULSE_CHANNELS        = 4,
    parameter int COUNTER_WIDTH         = 24,
    parameter int PING_PERIOD           = 1250,
    localparam int CHANNEL_SEL_WIDTH    = (PULSE_CHANNELS > 1) ? $clog2(PULSE_CHANNELS) : 1
) (
    input  logic                             evgTxClk,
    input  logic                             evgTxReset_n,
    input  logic                             evgHeartbeatRequest,
    input  logic [PULSE_CHANNELS-1:0]        evgChannelTrigger,
    input  logic                             cfgWrite,
    input  logic [CHANNEL_SEL_WIDTH-1:0]     cfgChannel,
    input  logic [1:0]                       cfgMode,
    input  logic [COUNTER_WIDTH-1:0]         cfgPeriod,
    input  logic [COUNTER_WIDTH-1:0]         cfgWidth,
    output logic [DISTRIBUTED_BUS_WIDTH-1:0] evgDistributedBus,
    output logic [PULSE_CHANNELS-1:0]        cfgPending,
    output logic [PULSE_CHANNELS-1:0]        cfgError
);

    localparam int PING_CNT_WIDTH = (PING_PERIOD > 2) ? $clog2(PING_PERIOD) : 1;
    localparam logic [PING_CNT_WIDTH-1:0] PING_RELOAD = PING_CNT_WIDTH'(PING_PERIOD - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_FREE    = 2'd1,
        MODE_HB      = 2'd2,
        MODE_ONESHOT = 2'd3
    } chanMode_t;

    typedef enum logic {
        OS_IDLE  = 1'b0,
        OS_PULSE = 1'b1
    } oneShotState_t;

    typedef struct packed {
        chanMode_t                mode;
        logic [COUNTER_WIDTH-1:0] period;
        logic [COUNTER_WIDTH-1:0] width;
    } chanCfg_t;

    // Full per-channel state, including the one-shot FSM, kept in one struct for probing.
    typedef struct packed {
        chanCfg_t                 cfg;
        logic [COUNTER_WIDTH-1:0] phase;
        oneShotState_t            osState;
    } chanState_t;

    localparam chanCfg_t   CFG_OFF   = '{mode: MODE_OFF, period: '0, width: '0};
    localparam chanState_t STATE_OFF = '{cfg: CFG_OFF, phase: '0, osState: OS_IDLE};

    logic                      hbBit;
    logic                      pingBit;
    logic [PING_CNT_WIDTH-1:0] pingCount;
    logic [PULSE_CHANNELS-1:0] chanOut;

    always_ff @(posedge evgTxClk or negedge evgTxReset_n) begin
        if (!evgTxReset_n) begin
            hbBit     <= 1'b0;
            pingBit   <= 1'b0;
            pingCount <= PING_RELOAD;
        end else begin
            hbBit <= evgHeartbeatRequest;
            if (pingCount == '0) begin
                pingCount <= PING_RELOAD;
                pingBit   <= 1'b1;
            end else begin
                pingCount <= pingCount - 1'b1;
                pingBit   <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < PULSE_CHANNELS; c++) begin : gChan
        chanState_t               st;
        chanCfg_t                 shadow;
        chanCfg_t                 writeCfg;
        logic                     outBit;
        logic                     pendingBit;
        logic                     errorBit;
        logic                     writeHit;
        logic                     writeValid;
        logic                     writeImmediate;
        logic                     atWrap;
        logic                     atPulseEnd;
        logic                     boundary;
        logic [COUNTER_WIDTH-1:0] runPhase;

        assign writeCfg       = '{mode: chanMode_t'(cfgMode), period: cfgPeriod, width: cfgWidth};
        assign writeHit       = cfgWrite && (cfgChannel == CHANNEL_SEL_WIDTH'(c));
        assign writeValid     = (cfgMode == 2'd0) ||
                                ((cfgPeriod >= COUNTER_WIDTH'(2)) && (cfgWidth != '0));
        assign writeImmediate = writeHit && writeValid &&
                                ((cfgMode == 2'd0) || (st.cfg.mode == MODE_OFF));

        // Compare against P-1 / W-1 rather than incrementing past them, so no overflow.
        assign atWrap     = !(st.phase < (st.cfg.period - 1'b1));
        assign atPulseEnd = !(st.phase < (st.cfg.width - 1'b1));
        assign runPhase   = (atWrap || ((st.cfg.mode == MODE_HB) && evgHeartbeatRequest)) ?
                            '0 : st.phase + 1'b1;

        always_comb begin
            boundary = 1'b0;
            case (st.cfg.mode)
                MODE_FREE:    boundary = atWrap;
                MODE_HB:      boundary = atWrap || evgHeartbeatRequest;
                MODE_ONESHOT: boundary = (st.osState == OS_IDLE) || atPulseEnd;
                default:      boundary = 1'b0;
            endcase
        end

        always_ff @(posedge evgTxClk or negedge evgTxReset_n) begin
            if (!evgTxReset_n) begin
                st         <= STATE_OFF;
                shadow     <= CFG_OFF;
                outBit     <= 1'b0;
                pendingBit <= 1'b0;
                errorBit   <= 1'b0;
            end else if (writeImmediate) begin
                st         <= '{cfg: writeCfg, phase: '0, osState: OS_IDLE};
                outBit     <= (cfgMode == 2'd1) || (cfgMode == 2'd2);
                pendingBit <= 1'b0;
                errorBit   <= 1'b0;
            end else begin
                if (pendingBit && boundary) begin
                    st         <= '{cfg: shadow, phase: '0, osState: OS_IDLE};
                    outBit     <= (shadow.mode == MODE_FREE) || (shadow.mode == MODE_HB);
                    pendingBit <= 1'b0;
                end else begin
                    case (st.cfg.mode)
                        MODE_FREE, MODE_HB: begin
                            st.phase <= runPhase;
                            outBit   <= (runPhase < st.cfg.width);
                        end
                        MODE_ONESHOT: begin
                            if (st.osState == OS_IDLE) begin
                                if (evgChannelTrigger[c]) begin
                                    st.osState <= OS_PULSE;
                                    st.phase   <= '0;
                                    outBit     <= 1'b1;
                                end else begin
                                    outBit <= 1'b0;
                                end
                            end else if (atPulseEnd) begin
                                st.osState <= OS_IDLE;
                                st.phase   <= '0;
                                outBit     <= 1'b0;
                            end else begin
                                st.phase <= st.phase + 1'b1;
                                outBit   <= 1'b1;
                            end
                        end
                        default: outBit <= 1'b0;
                    endcase
                end
                // A write landing on a boundary cycle is queued after the old shadow applies.
                if (writeHit) begin
                    if (writeValid) begin
                        shadow     <= writeCfg;
                        pendingBit <= 1'b1;
                        errorBit   <= 1'b0;
                    end else begin
                        errorBit <= 1'b1;
                    end
                end
            end
        end

        assign chanOut[c]    = outBit;
        assign cfgPending[c] = pendingBit;
        assign cfgError[c]   = errorBit;
    end

    always_comb begin
        evgDistributedBus                      = '0;
        evgDistributedBus[0]                   = hbBit;
        evgDistributedBus[1]                   = pingBit;
        evgDistributedBus[PULSE_CHANNELS+1:2]  = chanOut;
    end

endmodule

// File: tb/tb_evg_dbus_generator.sv
// Directed bench for evg_dbus_generator: expected bus/pending/error words are queued as each
// cycle is driven and compared one clock later.
module tb_evg_dbus_generator;

  localparam int PING = 10;

  logic        clk;
  logic        rst_n;
  logic        evgHeartbeatRequest;
  logic [3:0]  evgChannelTrigger;
  logic        cfgWrite;
  logic [1:0]  cfgChannel;
  logic [1:0]  cfgMode;
  logic [23:0] cfgPeriod;
  logic [23:0] cfgWidth;
  logic [7:0]  evgDistributedBus;
  logic [3:0]  cfgPending;
  logic [3:0]  cfgError;

  logic [15:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  evg_dbus_generator #(
    .DISTRIBUTED_BUS_WIDTH(8),
    .PULSE_CHANNELS(4),
    .COUNTER_WIDTH(24),
    .PING_PERIOD(PING)
  ) dut (
    .evgTxClk(clk),
    .evgTxReset_n(rst_n),
    .evgHeartbeatRequest(evgHeartbeatRequest),
    .evgChannelTrigger(evgChannelTrigger),
    .cfgWrite(cfgWrite),
    .cfgChannel(cfgChannel),
    .cfgMode(cfgMode),
    .cfgPeriod(cfgPeriod),
    .cfgWidth(cfgWidth),
    .evgDistributedBus(evgDistributedBus),
    .cfgPending(cfgPending),
    .cfgError(cfgError)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfgWrite = 1'b0;
    cfgChannel = '0;
    cfgMode = '0;
    cfgPeriod = '0;
    cfgWidth = '0;
    evgHeartbeatRequest = 1'b0;
    evgChannelTrigger = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_bus", 32'(evgDistributedBus), 32'h0);
    check_eq("rst_pend", 32'(cfgPending), 32'h0);
    check_eq("rst_err", 32'(cfgError), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // driver tasks
  task automatic wr(input int ch, input int mode, input int p, input int w);
    cfgWrite = 1'b1;
    cfgChannel = ch[1:0];
    cfgMode = mode[1:0];
    cfgPeriod = p[23:0];
    cfgWidth = w[23:0];
  endtask

  task automatic cycle(input string tag, input logic hb, input logic [3:0] trig,
                       input logic [3:0] exp_ch, input logic [3:0] exp_pend,
                       input logic [3:0] exp_err);
    logic        ping_e;
    logic [15:0] got;
    logic [15:0] e;
    evgHeartbeatRequest = hb;
    evgChannelTrigger = trig;
    cyc++;
    ping_e = ((cyc % PING) == 0);
    exp_q.push_back({exp_err, exp_pend, 2'b00, exp_ch, ping_e, hb});
    @(posedge clk);
    #1;
    cfgWrite = 1'b0;
    evgHeartbeatRequest = 1'b0;
    evgChannelTrigger = '0;
    got = {cfgError, cfgPending, evgDistributedBus};
    if (exp_q.size() == 0) begin
      check_eq({tag, "_qempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, 32'(got), 32'(e));
    end
  endtask

  initial begin
    logic [3:0] ch;
    logic [3:0] pend;
    logic [3:0] err;
    logic       hb;
    int         t;
    int         h;

    // T1: idle after reset, only ping toggles
    do_reset();
    for (int k = 1; k <= 30; k++) cycle($sformatf("t1_k%0d", k), 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

    // T2: ch0 free-run, then shadowed reconfiguration applied at the wrap
    do_reset();
    for (int k = 0; k < 26; k++) begin
      if (k == 0) wr(0, 1, 5, 2);
      if (k == 12) wr(0, 1, 4, 1);
      ch = '0;
      ch[0] = (k < 15) ? ((k % 5) < 2) : (((k - 15) % 4) < 1);
      pend = '0;
      pend[0] = (k >= 12) && (k < 15);
      cycle($sformatf("t2_k%0d", k), 1'b0, 4'h0, ch, pend, 4'h0);
    end

    // T3: ch1 heartbeat-aligned, realigned by heartbeats
    do_reset();
    for (int k = 0; k <= 50; k++) begin
      if (k == 0) wr(1, 2, 100, 3);
      hb = (k == 37) || (k == 42);
      ch = '0;
      if (k < 37) ch[1] = (k < 3);
      else if (k < 42) ch[1] = ((k - 37) < 3);
      else ch[1] = ((k - 42) < 3);
      cycle($sformatf("t3_k%0d", k), hb, 4'h0, ch, 4'h0, 4'h0);
    end

    // T4: ch2 one-shot, second trigger ignored, then held trigger
    do_reset();
    t = $urandom_range(2, 6);
    h = t + 10;
    for (int k = 0; k <= h + 18; k++) begin
      logic [3:0] trig;
      if (k == 0) wr(2, 3, 10, 4);
      trig = '0;
      trig[2] = (k == t) || (k == t + 2) || ((k >= h) && (k < h + 15));
      ch = '0;
      if ((k >= t) && (k <= t + 3)) ch[2] = 1'b1;
      if ((k >= h) && (k < h + 15)) ch[2] = (((k - h) % 5) < 4);
      cycle($sformatf("t4_k%0d", k), 1'b0, trig, ch, 4'h0, 4'h0);
    end

    // T5: ch3 invalid writes, error clear, mode 0 overriding a pending shadow
    do_reset();
    for (int k = 0; k <= 18; k++) begin
      if (k == 0) wr(3, 1, 1, 1);
      if (k == 3) wr(3, 1, 3, 1);
      if (k == 10) wr(3, 1, 3, 0);
      if (k == 13) wr(3, 1, 5, 2);
      if (k == 15) wr(3, 0, 0, 0);
      ch = '0;
      ch[3] = (k >= 3) && (k < 15) && (((k - 3) % 3) == 0);
      pend = '0;
      pend[3] = (k == 13) || (k == 14);
      err = '0;
      err[3] = (k < 3) || ((k >= 10) && (k < 13));
      cycle($sformatf("t5_k%0d", k), 1'b0, 4'h0, ch, pend, err);
    end

    // T6: write on the same cycle as a boundary, and W >= P
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      if (k == 0) wr(0, 1, 4, 1);
      if (k == 2) wr(0, 1, 6, 2);
      if (k == 4) wr(0, 1, 3, 3);
      ch = '0;
      if (k < 4) ch[0] = (k == 0);
      else if (k < 10) ch[0] = ((k - 4) < 2);
      else ch[0] = 1'b1;
      pend = '0;
      pend[0] = (k >= 2) && (k < 10);
      cycle($sformatf("t6_k%0d", k), 1'b0, 4'h0, ch, pend, 4'h0);
    end

    // T7: asynchronous reset in the middle of activity
    do_reset();
    wr(2, 3, 10, 4);
    cycle("t7_k0", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    wr(0, 1, 5, 2);
    cycle("t7_k1", 1'b0, 4'h4, 4'h5, 4'h0, 4'h0);
    wr(0, 1, 4, 1);
    cycle("t7_k2", 1'b0, 4'h0, 4'h5, 4'h1, 4'h0);
    wr(3, 1, 0, 0);
    cycle("t7_k3", 1'b0, 4'h0, 4'h4, 4'h1, 4'h8);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t7_async_bus", 32'(evgDistributedBus), 32'h0);
    check_eq("t7_async_pend", 32'(cfgPending), 32'h0);
    check_eq("t7_async_err", 32'(cfgError), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 12; k++) cycle($sformatf("t7_post_k%0d", k), 1'b0, 4'hf, 4'h0, 4'h0, 4'h0);

    check_eq("q_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
